// File: rtl/deal_pkg.sv
// deal_pkg: shared FSM states, card constants and baccarat value helper for deal_hand
package deal_pkg;
  localparam int CARD_W = 4;
  localparam int MAX_SLOTS = 3;
  localparam logic [CARD_W-1:0] CARD_BLANK = 4'd0;
  typedef enum logic [1:0] {IDLE, LOAD, ACK, NACK} state_t;
  function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] rank);
    return rank <= CARD_W'(9) ? rank : CARD_BLANK;
  endfunction
endpackage

// File: rtl/deal_hand_rank_counter.sv
// rank_counter: free-running card rank source cycling 1..NUM_RANKS, never 0
module rank_counter #(
  parameter int NUM_RANKS = 13,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] rank
);
  always_ff @(posedge clk)
    rank <= (reset || rank == W'(NUM_RANKS)) ? W'(1) : rank + W'(1);
endmodule

// File: rtl/deal_hand.sv
// deal_hand: handshaked dealer latching counter ranks into player/dealer hands with baccarat scores
// DEAL_FORCE_EN adds force_en/force_val to override the captured card.
module deal_hand #(
  parameter int NUM_RANKS = 13,
  parameter int CARD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
`ifdef DEAL_FORCE_EN
  input  logic              force_en,
  input  logic [CARD_W-1:0] force_val,
`endif
  input  logic              deal_req,
  input  logic              deal_to,
  output logic              deal_ack,
  output logic              deal_nack,
  output logic              busy,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [1:0]        pcount,
  output logic [1:0]        dcount,
  output logic [CARD_W-1:0] pscore,
  output logic [CARD_W-1:0] dscore
);
  import deal_pkg::*;
  state_t state;
  logic [CARD_W-1:0] rank, card_q, src, val, nscore;
  logic [CARD_W-1:0] pslot [MAX_SLOTS];
  logic [CARD_W-1:0] dslot [MAX_SLOTS];
  logic [4:0] sum;
  logic tgt_q;
  logic [1:0] tcnt;
  rank_counter #(.NUM_RANKS(NUM_RANKS), .W(CARD_W)) u_cnt (.clk(clk), .reset(reset), .rank(rank));
`ifdef DEAL_FORCE_EN
  assign src = force_en ? force_val : rank;
`else
  assign src = rank;
`endif
  // Five-bit sum: two values of at most 9 never exceed 18, so one subtract reduces mod 10
  always_comb begin
    tcnt = deal_to ? dcount : pcount;
    val = card_value(card_q);
    sum = 5'(tgt_q ? dscore : pscore) + 5'(val);
    nscore = sum >= 5'd10 ? CARD_W'(sum - 5'd10) : CARD_W'(sum);
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      deal_ack <= 1'b0;
      deal_nack <= 1'b0;
      busy <= 1'b0;
      pcount <= 2'd0;
      dcount <= 2'd0;
      pscore <= '0;
      dscore <= '0;
      card_q <= CARD_BLANK;
      tgt_q <= 1'b0;
      for (int i = 0; i < MAX_SLOTS; i++) begin
        pslot[i] <= CARD_BLANK;
        dslot[i] <= CARD_BLANK;
      end
    end else begin
      case (state)
        IDLE: if (deal_req) begin
          if (tcnt == 2'(MAX_SLOTS)) begin
            state <= NACK;
            deal_nack <= 1'b1;
          end else begin
            card_q <= src;
            tgt_q <= deal_to;
            busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (tgt_q) begin
            dslot[dcount] <= card_q;
            dcount <= dcount + 2'd1;
            dscore <= nscore;
          end else begin
            pslot[pcount] <= card_q;
            pcount <= pcount + 2'd1;
            pscore <= nscore;
          end
          deal_ack <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          deal_ack <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          deal_nack <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign {pcard1, pcard2, pcard3} = {pslot[0], pslot[1], pslot[2]};
  assign {dcard1, dcard2, dcard3} = {dslot[0], dslot[1], dslot[2]};
endmodule

// File: tb/tb_deal_hand.sv
// tb_deal_hand: directed and randomized deals checked against a queue-based hand model
module tb_deal_hand;
  localparam int NR = 13;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, deal_req = 1'b0, deal_to = 1'b0;
  logic deal_ack, deal_nack, busy;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic [1:0] pcount, dcount;
`ifdef DEAL_FORCE_EN
  logic force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
`endif
  int n = 0, fails = 0, cyc = 0;
  int ph[$], dh[$];

  deal_hand #(.NUM_RANKS(NR), .CARD_W(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
`ifdef DEAL_FORCE_EN
    .force_en(force_en), .force_val(force_val),
`endif
    .deal_req(deal_req), .deal_to(deal_to), .deal_ack(deal_ack), .deal_nack(deal_nack), .busy(busy),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pcount(pcount), .dcount(dcount), .pscore(pscore), .dscore(dscore));

  always #5 clk = ~clk;
  // Edges since the last reset edge; the rank seen in a cycle follows directly from it
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  function automatic int mrank();
    return cyc % NR + 1;
  endfunction
  function automatic int slotv(input int q[$], input int i);
    return i < q.size() ? q[i] : 0;
  endfunction
  function automatic int score(input int q[$]);
    int s = 0;
    foreach (q[i]) s += (q[i] <= 9) ? q[i] : 0;
    return s % 10;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_hands();
    chk("pcard1", 8'(pcard1), 8'(slotv(ph, 0)));
    chk("pcard2", 8'(pcard2), 8'(slotv(ph, 1)));
    chk("pcard3", 8'(pcard3), 8'(slotv(ph, 2)));
    chk("dcard1", 8'(dcard1), 8'(slotv(dh, 0)));
    chk("dcard2", 8'(dcard2), 8'(slotv(dh, 1)));
    chk("dcard3", 8'(dcard3), 8'(slotv(dh, 2)));
    chk("pcount", 8'(pcount), 8'(ph.size()));
    chk("dcount", 8'(dcount), 8'(dh.size()));
    chk("pscore", 8'(pscore), 8'(score(ph)));
    chk("dscore", 8'(dscore), 8'(score(dh)));
  endtask

  // Raise a request now (at a negedge); card is the rank seen in this acceptance cycle
  task automatic deal(input logic to, input bit hold);
    int c;
    bit full;
    c = mrank();
    full = to ? dh.size() == 3 : ph.size() == 3;
    deal_req = 1'b1;
    deal_to = to;
    @(negedge clk);
    if (full) begin
      chk("nack", 8'(deal_nack), 8'd1);
      chk("nack_no_ack", 8'(deal_ack), 8'd0);
      chk("nack_busy", 8'(busy), 8'd0);
      deal_req = 1'b0;
      @(negedge clk);
      chk("nack_pulse", 8'(deal_nack), 8'd0);
      check_hands();
    end else begin
      chk("load_busy", 8'(busy), 8'd1);
      chk("load_no_ack", 8'(deal_ack), 8'd0);
      @(negedge clk);
      chk("ack", 8'(deal_ack), 8'd1);
      chk("ack_busy", 8'(busy), 8'd1);
      chk("ack_no_nack", 8'(deal_nack), 8'd0);
      if (to) dh.push_back(c); else ph.push_back(c);
      check_hands();
      if (!hold) deal_req = 1'b0;
      @(negedge clk);
      chk("ack_pulse", 8'(deal_ack), 8'd0);
      chk("idle_busy", 8'(busy), 8'd0);
    end
  endtask

  task automatic wait_rank(input int r);
    for (int i = 0; i < NR && mrank() != r; i++) @(negedge clk);
    chk("wait_rank", 8'(mrank()), 8'(r));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ph.delete();
    dh.delete();
    check_hands();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack", 8'(deal_ack), 8'd0);
    chk("rst_nack", 8'(deal_nack), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rank", 8'(dut.u_cnt.rank), 8'd1);
    check_hands();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("rank_cycle", 8'(dut.u_cnt.rank), 8'(mrank()));
      @(negedge clk);
    end
    check_hands();
    // Dealer K, Q, 9 then a fourth request is refused
    wait_rank(13); deal(1'b1, 1'b0);
    wait_rank(12); deal(1'b1, 1'b0);
    wait_rank(9);  deal(1'b1, 1'b0);
    chk("dscore_kq9", 8'(dscore), 8'd9);
    deal(1'b1, 1'b0);
    chk("rank_after_wrap", 8'(dut.u_cnt.rank), 8'(mrank()));
    // Player 7 then 8 gives score 5
    wait_rank(7); deal(1'b0, 1'b0);
    wait_rank(8); deal(1'b0, 1'b0);
    chk("pscore_78", 8'(pscore), 8'd5);
    do_clear();
    // Clear during LOAD aborts the deal silently
    deal_req = 1'b1;
    deal_to = 1'b0;
    @(negedge clk);
    chk("abort_load_busy", 8'(busy), 8'd1);
    clear = 1'b1;
    deal_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    chk("abort_no_ack", 8'(deal_ack), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    check_hands();
    @(negedge clk);
    chk("abort_no_late_ack", 8'(deal_ack), 8'd0);
    deal(1'b0, 1'b0);
    // Clear and request together in IDLE: request ignored
    deal_req = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    clear = 1'b0;
    ph.delete();
    dh.delete();
    chk("clr_req_busy", 8'(busy), 8'd0);
    check_hands();
    // Back-to-back with req held across the ack
    deal(1'b0, 1'b1);
    deal(1'b0, 1'b0);
    // Reset mid-deal restores reset values including the counter
    deal_req = 1'b1;
    deal_to = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    deal_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ph.delete();
    dh.delete();
    chk("mid_rst_rank", 8'(dut.u_cnt.rank), 8'd1);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_ack", 8'(deal_ack), 8'd0);
    check_hands();
    // Randomized deals, gaps and occasional clears
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 15) == 0) do_clear();
      deal(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      deal_req = 1'b0;
    end
    chk("rank_end", 8'(dut.u_cnt.rank), 8'(mrank()));
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
